// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI register bank behind the APB slave FSM.
// Holds CTRL and CLKDIV, a TX FIFO feeding the shift engine, and an RX FIFO
// filled by it. Read data and the error flag are registered one cycle after
// the strobe.
// Optional interrupt block: define SPI_REG_BANK_IRQ_EN to add INT_EN/INT_STAT
// and a live irq_out. Without it, those offsets are unmapped and irq_out is 0.
module spi_reg_bank #(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] SPI_REG_BASE = 32'ha0300000,
   parameter int                    FIFO_DEPTH   = 4,
   parameter int                    FRAME_WIDTH  = 8
) (
   input  logic                   apb_clk_in,
   input  logic                   apb_rstn_in,
   input  logic [ADDR_WIDTH-1:0]  reg_addr_in,
   input  logic                   reg_wr_en_in,
   input  logic                   reg_rd_en_in,
   input  logic [DATA_WIDTH-1:0]  reg_wdata_in,
   output logic [DATA_WIDTH-1:0]  reg_rdata_out,
   output logic                   reg_err_out,
   output logic                   ctrl_en_out,
   output logic                   ctrl_cpol_out,
   output logic                   ctrl_cpha_out,
   output logic                   ctrl_lsb_first_out,
   output logic                   ctrl_ss_out,
   output logic [15:0]            clkdiv_out,
   output logic                   tx_valid_out,
   output logic [FRAME_WIDTH-1:0] tx_data_out,
   input  logic                   tx_ready_in,
   input  logic                   rx_valid_in,
   input  logic [FRAME_WIDTH-1:0] rx_data_in,
   input  logic                   busy_in,
   output logic                   irq_out
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   localparam logic [4:0] OFF_CTRL     = 5'h00;
   localparam logic [4:0] OFF_CLKDIV   = 5'h04;
   localparam logic [4:0] OFF_STATUS   = 5'h08;
   localparam logic [4:0] OFF_TXDATA   = 5'h0C;
   localparam logic [4:0] OFF_RXDATA   = 5'h10;
   localparam logic [4:0] OFF_INT_EN   = 5'h14;
   localparam logic [4:0] OFF_INT_STAT = 5'h18;

   // Register state
   logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
   logic                   err_q, err_d;
   logic [4:0]             ctrl_q;
   logic [15:0]            clkdiv_q;
   logic                   ovf_q, ovf_d;

   // FIFO state
   logic [FRAME_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
   logic [FRAME_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
   logic [PW-1:0]          tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
   logic [CW-1:0]          tx_cnt_q, rx_cnt_q;

   logic                   hit, mapped;
   logic [4:0]             offset;
   logic                   tx_empty, tx_full, rx_empty, rx_full;
   logic                   tx_push, tx_pop, rx_push, rx_pop;
   logic                   status_clr;
   logic [DATA_WIDTH-1:0]  status_w, rxdata_w;

`ifdef SPI_REG_BANK_IRQ_EN
   logic [2:0]             int_en_q, int_stat_q, int_stat_d, cond_prev_q, cond_w;
   logic                   irq_q;
`endif

   assign offset   = reg_addr_in[4:0];
   assign hit      = (reg_addr_in[ADDR_WIDTH-1:5] == SPI_REG_BASE[ADDR_WIDTH-1:5]) &&
                     (reg_addr_in[1:0] == 2'b00);

   assign tx_empty = (tx_cnt_q == '0);
   assign tx_full  = (tx_cnt_q == DEPTH_C);
   assign rx_empty = (rx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == DEPTH_C);

   assign tx_valid_out = ctrl_q[0] && !tx_empty;
   assign tx_data_out  = tx_mem_q[tx_rptr_q];

   // A full FIFO rejects a push even when a pop happens in the same cycle.
   assign tx_pop     = tx_valid_out && tx_ready_in;
   assign tx_push    = reg_wr_en_in && hit && (offset == OFF_TXDATA) && !tx_full;
   assign rx_push    = rx_valid_in && !rx_full;
   assign rx_pop     = reg_rd_en_in && hit && (offset == OFF_RXDATA) && !rx_empty;
   assign status_clr = reg_wr_en_in && hit && (offset == OFF_STATUS) && reg_wdata_in[5];

   // Decode the offset, assemble read data and the error flag for this strobe
   always_comb begin
      mapped   = 1'b0;
      status_w = '0;
      rxdata_w = '0;
      rdata_d  = '0;
      status_w[5:0]           = {ovf_q, busy_in, rx_full, rx_empty, tx_full, tx_empty};
      rxdata_w[FRAME_WIDTH-1:0] = rx_mem_q[rx_rptr_q];
      case (offset)
         OFF_CTRL, OFF_CLKDIV, OFF_STATUS, OFF_TXDATA, OFF_RXDATA: mapped = 1'b1;
`ifdef SPI_REG_BANK_IRQ_EN
         OFF_INT_EN, OFF_INT_STAT: mapped = 1'b1;
`endif
         default: mapped = 1'b0;
      endcase
      err_d = !hit || !mapped ||
              (reg_wr_en_in && (offset == OFF_TXDATA) && tx_full) ||
              (reg_rd_en_in && (offset == OFF_RXDATA) && rx_empty);
      if (reg_rd_en_in && !err_d) begin
         case (offset)
            OFF_CTRL:     rdata_d[4:0]  = ctrl_q;
            OFF_CLKDIV:   rdata_d[15:0] = clkdiv_q;
            OFF_STATUS:   rdata_d       = status_w;
            OFF_RXDATA:   rdata_d       = rxdata_w;
`ifdef SPI_REG_BANK_IRQ_EN
            OFF_INT_EN:   rdata_d[2:0]  = int_en_q;
            OFF_INT_STAT: rdata_d[2:0]  = int_stat_q;
`endif
            default:      rdata_d       = '0;
         endcase
      end
      // Overflow set beats a software clear landing in the same cycle.
      ovf_d = ovf_q;
      if (status_clr) ovf_d = 1'b0;
      if (rx_valid_in && rx_full) ovf_d = 1'b1;
   end

   // Register file, read response and sticky overflow flag
   always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
      if (!apb_rstn_in) begin
         rdata_q  <= '0;
         err_q    <= 1'b0;
         ctrl_q   <= '0;
         clkdiv_q <= 16'd2;
         ovf_q    <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         if (reg_rd_en_in || reg_wr_en_in) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
         end
         if (reg_wr_en_in && !err_d) begin
            if (offset == OFF_CTRL)   ctrl_q   <= reg_wdata_in[4:0];
            if (offset == OFF_CLKDIV) clkdiv_q <= (reg_wdata_in[15:0] == 16'd0) ? 16'd1
                                                                               : reg_wdata_in[15:0];
         end
      end
   end

   // FIFO pointers and occupancy counts
   always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
      if (!apb_rstn_in) begin
         tx_wptr_q <= '0;
         tx_rptr_q <= '0;
         tx_cnt_q  <= '0;
         rx_wptr_q <= '0;
         rx_rptr_q <= '0;
         rx_cnt_q  <= '0;
      end else begin
         if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
         if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
         if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + 1'b1;
         else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - 1'b1;
         if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
         if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
         if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + 1'b1;
         else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - 1'b1;
      end
   end

   // FIFO storage; data only, so no reset
   always_ff @(posedge apb_clk_in) begin
      if (tx_push) tx_mem_q[tx_wptr_q] <= reg_wdata_in[FRAME_WIDTH-1:0];
      if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data_in;
   end

   assign ctrl_en_out        = ctrl_q[0];
   assign ctrl_cpol_out      = ctrl_q[1];
   assign ctrl_cpha_out      = ctrl_q[2];
   assign ctrl_lsb_first_out = ctrl_q[3];
   assign ctrl_ss_out        = ctrl_q[4];
   assign clkdiv_out         = clkdiv_q;
   assign reg_rdata_out      = rdata_q;
   assign reg_err_out        = err_q;

`ifdef SPI_REG_BANK_IRQ_EN
   assign cond_w = {ovf_q, !rx_empty, tx_empty};

   // Edge-detected status bits; a new edge wins over a W1C in the same cycle
   always_comb begin
      int_stat_d = int_stat_q;
      if (reg_wr_en_in && hit && (offset == OFF_INT_STAT))
         int_stat_d = int_stat_d & ~reg_wdata_in[2:0];
      int_stat_d = int_stat_d | (cond_w & ~cond_prev_q);
   end

   // Interrupt enable, status, condition history and registered irq
   always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
      if (!apb_rstn_in) begin
         int_en_q    <= '0;
         int_stat_q  <= '0;
         cond_prev_q <= 3'b001;
         irq_q       <= 1'b0;
      end else begin
         if (reg_wr_en_in && hit && (offset == OFF_INT_EN)) int_en_q <= reg_wdata_in[2:0];
         int_stat_q  <= int_stat_d;
         cond_prev_q <= cond_w;
         irq_q       <= |(int_en_q & int_stat_q);
      end
   end

   assign irq_out = irq_q;
`else
   assign irq_out = 1'b0;
`endif

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
Register bank and data buffering stage directly downstream of the SPI APB slave front end. It consumes single-cycle register read/write strobes decoded by the APB FSM and returns read data and an error flag. It holds the SPI control and clock-divider registers, a TX FIFO and an RX FIFO, and runs a valid/ready handshake with the SPI shift engine.

Parameters:
DATA_WIDTH, 32, register/APB data width
ADDR_WIDTH, 32, APB address width
SPI_REG_BASE, 32'ha0300000, base address of the register window (32-byte aligned)
FIFO_DEPTH, 4, TX and RX FIFO depth; must be a power of 2, minimum 2
FRAME_WIDTH, 8, SPI frame width in bits; must be ≤ DATA_WIDTH

Ports:
apb_clk_in  in  1  clock; all state on posedge
apb_rstn_in  in  1  asynchronous active-low reset
reg_addr_in  in  ADDR_WIDTH  transfer address
reg_wr_en_in  in  1  one-cycle write strobe
reg_rd_en_in  in  1  one-cycle read strobe; never asserted in the same cycle as reg_wr_en_in
reg_wdata_in  in  DATA_WIDTH  write data
reg_rdata_out  out  DATA_WIDTH  read data, registered
reg_err_out  out  1  error flag, registered, aligned with reg_rdata_out
ctrl_en_out, ctrl_cpol_out, ctrl_cpha_out, ctrl_lsb_first_out, ctrl_ss_out  out  1 each  CTRL[0..4]
clkdiv_out  out  16  CLKDIV[15:0]
tx_valid_out  out  1  TX FIFO not empty and ctrl_en_out = 1
tx_data_out  out  FRAME_WIDTH  TX FIFO head
tx_ready_in  in  1  shift engine accepts the head
rx_valid_in  in  1  one-cycle strobe: received frame present
rx_data_in  in  FRAME_WIDTH  received frame
busy_in  in  1  shift engine busy
irq_out  out  1  interrupt, active high

Behaviour:
- Reset is asynchronous on apb_rstn_in. Reset values: reg_rdata_out=0, reg_err_out=0, CTRL=0, CLKDIV=16'd2, both FIFOs empty (pointers and count = 0), overflow flag=0, INT_EN=0, INT_STAT=0, irq_out=0.
- Address decode: hit when reg_addr_in[ADDR_WIDTH-1:5] == SPI_REG_BASE[ADDR_WIDTH-1:5] and reg_addr_in[1:0] == 0. Offset = reg_addr_in[4:0].
- Register map:
  - 0x00 CTRL, RW, bits [4:0].
  - 0x04 CLKDIV, RW, bits [15:0]. A write of 0 is stored as 1.
  - 0x08 STATUS, RO except bit 5. Bits: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] busy_in, [5] rx_overflow. Bit 5 is sticky; writing 1 to bit 5 clears it.
  - 0x0C TXDATA, WO. A write pushes reg_wdata_in[FRAME_WIDTH-1:0] into the TX FIFO. Reads return 0 with no error.
  - 0x10 RXDATA, RO. A read pops the RX FIFO; the returned frame is zero-extended to DATA_WIDTH.
  - 0x14 INT_EN, 0x18 INT_STAT: see Optional Feature.
  - All unused bits read 0.
- Latency: reg_rdata_out and reg_err_out update on the clock edge after the strobe is sampled and hold until the next strobe. A write strobe also updates reg_err_out and sets reg_rdata_out to 0.
- reg_err_out=1 when any of these occur:
  - address miss;
  - misaligned address;
  - unmapped offset;
  - TXDATA write while the TX FIFO is full (data dropped, no state change);
  - RXDATA read while the RX FIFO is empty (returns 0, pointers unchanged).
- TX FIFO:
  - Pops when tx_valid_out & tx_ready_in.
  - A push and a pop in the same cycle both occur; count is unchanged.
  - A push when full is rejected even if a pop occurs in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- RX FIFO:
  - Pushes when rx_valid_in = 1.
  - A push when full drops the frame and sets rx_overflow. This applies even if a CPU pop occurs in the same cycle.
  - A simultaneous push and pop on a non-full FIFO both occur.
- Clearing CTRL[0] does not flush either FIFO. It only gates tx_valid_out.
- Writes to RO registers are ignored with no error, except the STATUS bit 5 clear.

Optional Feature:
Macro SPI_REG_BANK_IRQ_EN.
- Defined:
  - INT_EN (RW, [2:0]) and INT_STAT (W1C, [2:0]) are present. INT_STAT bits: [0] tx_empty, [1] rx_not_empty, [2] rx_overflow.
  - A bit is set on the rising edge of its condition and cleared by writing 1.
  - If a set and a clear land in the same cycle, set wins.
  - irq_out is registered: irq_out = |(INT_EN & INT_STAT).
- Not defined:
  - Offsets 0x14 and 0x18 are unmapped: accesses give reg_err_out=1 and read 0.
  - irq_out is tied to 0.

Test Plan:
1. Reset, then read 0x08, 0x04, 0x00 → STATUS=0x05, CLKDIV=0x0002, CTRL=0; reg_err_out=0 on each read.
2. Write CTRL=0x01. Write TXDATA 0xA5, 0x5A, 0x11, 0x22, 0x33 with tx_ready_in=0 → the first four are accepted; the 5th gives reg_err_out=1 and STATUS[1]=1. Raise tx_ready_in → tx_data_out sequence is A5, 5A, 11, 22, then tx_valid_out=0.
3. Pulse rx_valid_in with 0x10..0x14 (5 frames) → STATUS[5]=1 and STATUS[3]=1. Reading RXDATA 5 times returns 0x10, 0x11, 0x12, 0x13, then 0 with reg_err_out=1. Write 0x20 to STATUS → bit 5 clears.
4. Read 0xA0300020 and 0xA0300002 → reg_err_out=1 and reg_rdata_out=0 for each. Write CLKDIV=0 → reads back 1.
5. Fill the TX FIFO and hold it full. In one cycle, write TXDATA while tx_ready_in pops → the write is rejected (err=1) and count goes 4 → 3.
6. IRQ_EN build: INT_EN=0x2, push an RX frame → irq_out=1 within 2 cycles. Write INT_STAT=0x2 while no new frame arrives → irq_out=0. Non-IRQ build: read 0x14 → err=1 and irq_out stays 0.
